frame_readout_seq: RTL and testbench



---
 rtl/frame_pkg.sv | 14 +
 rtl/frame_readout_seq_if.sv | 23 ++
 rtl/frame_skid_fifo.sv | 55 +++++
 rtl/frame_readout_seq.sv | 85 ++++++++
 tb/tb_frame_readout_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared widths, frame length, sequencer state encoding and bit-reverse helper
// for the frame buffer read path.
package frame_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int FRAME_LEN = 1 << DEF_ADDR_W;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = a[w-1-i];
        return r;
    endfunction
endpackage

// File: rtl/frame_readout_seq_if.sv
// frame_readout_seq_if: synchronous frame RAM read port plus the valid/ready sample stream.
interface frame_readout_seq_if
    import frame_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    modport master (
        output rd_en, rd_addr, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );
    modport slave (
        input  rd_en, rd_addr, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/frame_skid_fifo.sv
// frame_skid_fifo: 2-entry fall-through FIFO of sample data plus a last tag; an empty FIFO
// presents the arriving push directly so a sample can leave in the cycle it lands.
module frame_skid_fifo
    import frame_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [1:0]        count
);
    logic [DATA_W:0] mem_q [2];
    logic [DATA_W:0] mem_d [2];
    logic [DATA_W:0] head;
    logic            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            empty, wr, rd;

    always_comb begin
        empty = count_q == 2'd0;
        head = empty ? {push_last, push_data} : mem_q[rd_ptr_q];
        head_valid = !empty || push;
        head_data = head_valid ? head[DATA_W-1:0] : '0;
        head_last = head_valid && head[DATA_W];
        wr = push && !(empty && pop);
        rd = pop && !empty;
        mem_d = mem_q;
        if (wr) mem_d[wr_ptr_q] = {push_last, push_data};
        wr_ptr_d = wr_ptr_q ^ wr;
        rd_ptr_d = rd_ptr_q ^ rd;
        count_d = count_q + 2'(wr) - 2'(rd);
        count = count_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/frame_readout_seq.sv
// frame_readout_seq: reads one 2^ADDR_W-sample frame from the synchronous frame RAM and streams it
// out over valid/ready. Define FRAME_BITREV_EN to issue addresses in bit-reversed order.
module frame_readout_seq
    import frame_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic start,
    input  logic frame_rdy,
    output logic busy,
    output logic done,
    frame_readout_seq_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              pop, issue;
    logic [DATA_W-1:0] head_data;
    logic              head_last, head_valid;

    frame_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .Clk,
        .Rst_n,
        .push(inflight_q),
        .push_data(bus.rd_data),
        .push_last(inflight_last_q),
        .pop,
        .head_data,
        .head_last,
        .head_valid,
        .count(fifo_count)
    );

    // occupancy counts the read in flight so the 2-entry FIFO can never overflow
    always_comb begin
        pop = head_valid && bus.out_ready;
        occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue = state_q == STREAM && occ < 3'd2;
        inflight_d = issue;
        inflight_last_d = issue && rcnt_q == LAST_IDX;
        rcnt_d = issue ? rcnt_q + 1'b1 : rcnt_q;
        state_d = state_q;
        case (state_q)
            IDLE: if (start && frame_rdy) begin
                state_d = STREAM;
                rcnt_d = '0;
            end
            STREAM: if (inflight_last_d) state_d = DRAIN;
            DRAIN: if (pop && head_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            rcnt_q <= '0;
            inflight_q <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q <= rcnt_d;
            inflight_q <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign bus.rd_en = issue;
`ifdef FRAME_BITREV_EN
    assign bus.rd_addr = ADDR_W'(bitrev(32'(rcnt_q), ADDR_W));
`else
    assign bus.rd_addr = rcnt_q;
`endif
    assign bus.out_data = head_data;
    assign bus.out_valid = head_valid;
    assign bus.out_last = head_last;
    assign busy = state_q == STREAM || state_q == DRAIN;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_frame_readout_seq.sv
// tb_frame_readout_seq: directed bench for frame_readout_seq; a beat-indexed stream model checks
// every cycle, and literal expectations pin latency, first/last samples and done counts.
`timescale 1ns/1ps
module tb_frame_readout_seq;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LEN = 512;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic frame_rdy = 1'b0;
    logic busy, done;
    int tests = 0;
    int fails = 0;
    int cyc = 0, beat = 0, issued = 0, start_cyc = 0, first_lat = -1, done_lat = -1, done_cnt = 0;
    logic exp_busy = 1'b0, exp_done = 1'b0, first_seen = 1'b0, stall_q = 1'b0;
    logic [DW-1:0] got0 = '0, got1 = '0, got_last = '0;
    logic mode = 1'b0;
    logic [1:0] phase = 2'd0;
    logic [3:0] pat = 4'b1001;

    frame_readout_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    frame_readout_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(clk), .Rst_n(rst_n), .start(start), .frame_rdy(frame_rdy),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_addr(input int k);
`ifdef FRAME_BITREV_EN
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) & 1);
        return AW'(r);
`else
        return AW'(k);
`endif
    endfunction

    function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
        return 16'h1000 + DW'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram(bus.rd_addr);

    always @(negedge clk) begin
        logic p, acc;
        if (!rst_n) begin
            check("rst_done", 32'(done), 32'd0);
            exp_busy = 1'b0;
            exp_done = 1'b0;
            beat = 0;
            issued = 0;
            stall_q = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                done_cnt++;
                done_lat = cyc - start_cyc;
                check("beats_per_frame", 32'(beat), 32'(LEN));
            end
            if (bus.rd_en) begin
                check("rd_en_in_frame", 32'({exp_busy, issued < LEN}), 32'd3);
                check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr(issued)));
                issued++;
            end
            if (stall_q) check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("valid_in_frame", 32'(bus.out_valid && !exp_busy), 32'd0);
            if (bus.out_valid) begin
                check("out_data", 32'(bus.out_data), 32'(ram(exp_addr(beat))));
                check("out_last", 32'(bus.out_last), 32'(beat == LEN - 1));
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_lat = cyc - start_cyc;
                end
            end
            p = bus.out_valid && bus.out_ready;
            if (p) begin
                if (beat == 0) got0 = bus.out_data;
                if (beat == 1) got1 = bus.out_data;
                if (bus.out_last) got_last = bus.out_data;
                beat++;
            end
            check("outstanding", 32'(issued - beat <= 2), 32'd1);
            stall_q = bus.out_valid && !bus.out_ready;
            acc = !exp_busy && !exp_done && start && frame_rdy;
            exp_done = exp_busy && p && beat == LEN;
            exp_busy = exp_busy ? !(p && beat == LEN) : acc;
            if (acc) begin
                start_cyc = cyc;
                beat = 0;
                issued = 0;
                first_seen = 1'b0;
            end
        end
        cyc++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        phase = phase + 2'd1;
        bus.out_ready = mode ? pat[phase] : 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cycle();
        check("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_beat(input int n, input int budget);
        for (int i = 0; i < budget && beat < n; i++) cycle();
        check("beat_timeout", 32'(beat >= n), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        check_all_zero("reset");
        rst_n = 1'b1;
        cycle();
        // natural back-pressure-free frame
        frame_rdy = 1'b1;
        pulse_start();
        wait_done(2000);
        check("first_latency", 32'(first_lat), 32'd2);
        check("done_latency", 32'(done_lat), 32'd514);
        check("beat0_data", 32'(got0), 32'h1000);
`ifdef FRAME_BITREV_EN
        check("beat1_data", 32'(got1), 32'h1100);
`else
        check("beat1_data", 32'(got1), 32'h1001);
`endif
        check("last_data", 32'(got_last), 32'h11FF);
        check("done_count_1", 32'(done_cnt), 32'd1);
        // out_ready 1,0,0,1 pattern
        mode = 1'b1;
        pulse_start();
        wait_done(4000);
        check("done_count_2", 32'(done_cnt), 32'd2);
        check("first_latency_bp", 32'(first_lat), 32'd2);
        mode = 1'b0;
        // start without frame_rdy is dropped
        frame_rdy = 1'b0;
        pulse_start();
        repeat (5) cycle();
        check("ignored_start_busy", 32'(busy), 32'd0);
        frame_rdy = 1'b1;
        pulse_start();
        wait_done(2000);
        check("done_count_3", 32'(done_cnt), 32'd3);
        // start while busy, frame_rdy dropping mid-frame
        pulse_start();
        wait_beat(100, 2000);
        pulse_start();
        frame_rdy = 1'b0;
        wait_done(2000);
        repeat (10) cycle();
        check("done_count_4", 32'(done_cnt), 32'd4);
        check("idle_after_busy_start", 32'(busy), 32'd0);
        // asynchronous reset mid-frame
        frame_rdy = 1'b1;
        pulse_start();
        wait_beat(300, 2000);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) cycle();
        check("no_done_after_abort", 32'(done_cnt), 32'd4);
        rst_n = 1'b1;
        cycle();
        pulse_start();
        wait_done(2000);
        check("done_count_5", 32'(done_cnt), 32'd5);
        check("first_latency_after_rst", 32'(first_lat), 32'd2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
